// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Stall/flush controller for the six-stage SampleCPU pipeline (PC, IF, ID, EX, MEM, WB).
// Each level stall request freezes its own stage and every earlier stage.
// A timed request holds EX stalled for a programmed number of cycles.
// A flush aborts any timed stall, drives the redirect PC and then holds the PC stage
// for FLUSH_HOLD cycles so the refetch can settle.
//
// Ports:
//   clk           clock; all state changes on the rising edge
//   rst           synchronous reset, active-high
//   stallreq      NREQ level stall requests; field i of REQ_STAGE names the stage for bit i
//   timed_req     one-cycle pulse that starts a timed stall
//   timed_cycles  total stalled cycles for the timed stall, including the request cycle
//   flush_req     flush the pipeline in this cycle
//   flush_pc      redirect target, valid together with flush_req
//   stall         stall[j] = 1 freezes stage j (thermometer mask from stage 0)
//   flush         flush strobe to the IF..MEM pipeline registers
//   new_pc        redirect PC while flush = 1, otherwise 0
//   busy          timed stall or post-flush hold in progress
//   stall_cycles  saturating count of cycles with stall[0] = 1
module pipe_hazard_ctrl #(
    parameter int                     STAGES      = 6,
    parameter int                     NREQ        = 3,
    parameter int                     IDX_W       = 3,
    parameter logic [NREQ*IDX_W-1:0]  REQ_STAGE   = {3'd3, 3'd2, 3'd3},
    parameter int                     TIMED_STAGE = 3,
    parameter int                     CNT_W       = 6,
    parameter int                     FLUSH_HOLD  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   stallreq,
    input  logic              timed_req,
    input  logic [CNT_W-1:0]  timed_cycles,
    input  logic              flush_req,
    input  logic [31:0]       flush_pc,
    output logic [STAGES-1:0] stall,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic              busy,
    output logic [31:0]       stall_cycles
);

    typedef enum logic [1:0] {RUN, TSTALL, FHOLD} state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              timed_start;
    logic              timed_active;
    logic [STAGES-1:0] stage_mask;

    // Mask with bits 0..k set; OR-ing masks of several stages yields the mask of the deepest one.
    function automatic logic [STAGES-1:0] therm(input int k);
        logic [STAGES-1:0] m;
        for (int j = 0; j < STAGES; j++) begin
            m[j] = (j <= k);
        end
        return m;
    endfunction

    // A timed request is honoured only from RUN; a concurrent flush discards it.
    assign timed_start  = (state == RUN) && timed_req && (timed_cycles != '0) && !flush_req;
    assign timed_active = (state == TSTALL) || timed_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // cnt holds the remaining stalled cycles including the current one, so leave at cnt == 1.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (flush_req) begin
            if (FLUSH_HOLD > 0) begin
                state_next = FHOLD;
                cnt_next   = CNT_W'(FLUSH_HOLD);
            end else begin
                state_next = RUN;
                cnt_next   = '0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (timed_req && (timed_cycles >= CNT_W'(2))) begin
                        state_next = TSTALL;
                        cnt_next   = timed_cycles - CNT_W'(1);
                    end
                end
                TSTALL, FHOLD: begin
                    if (cnt <= CNT_W'(1)) begin
                        state_next = RUN;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Reset and flush both force the stall vector to zero in the same cycle.
    always_comb begin
        stage_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (stallreq[i]) begin
                stage_mask = stage_mask | therm(int'(REQ_STAGE[i*IDX_W +: IDX_W]));
            end
        end
        if (timed_active) begin
            stage_mask = stage_mask | therm(TIMED_STAGE);
        end
        if (state == FHOLD) begin
            stage_mask = stage_mask | therm(0);
        end
        stall  = (rst || flush_req) ? '0 : stage_mask;
        flush  = !rst && flush_req;
        new_pc = (!rst && flush_req) ? flush_pc : 32'h0;
        busy   = !rst && (state != RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 32'h0;
        end else if (stall[0] && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'h1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
// Drives pipe_hazard_ctrl with directed sequences and random traffic. Each cycle the expected
// outputs come from a remaining-cycles model of the controller and are queued; a separate
// monitor pops and compares them half a cycle later.
module tb_pipe_hazard_ctrl;

    localparam int FLUSH_HOLD = 1;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        busy;
        logic [31:0] sc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  stallreq = 3'b000;
    logic        timed_req = 1'b0;
    logic [5:0]  timed_cycles = 6'd0;
    logic        flush_req = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        busy;
    logic [31:0] stall_cycles;

    exp_t        expQ[$];
    int          checks = 0;
    int          errors = 0;

    int          modelTRemain = 0;
    int          modelHold    = 0;
    logic [31:0] modelSc      = 32'h0;

    pipe_hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq     (stallreq),
        .timed_req    (timed_req),
        .timed_cycles (timed_cycles),
        .flush_req    (flush_req),
        .flush_pc     (flush_pc),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .busy         (busy),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    // Stage raising each level request: bit0 -> EX, bit1 -> ID, bit2 -> EX.
    function automatic int reqStage(input int i);
        int s;
        case (i)
            0:       s = 3;
            1:       s = 2;
            default: s = 3;
        endcase
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs, then advance the model past the edge.
    task automatic applyStimulus(input logic r, input logic [2:0] req, input logic tr,
                                 input logic [5:0] tc, input logic fr, input logic [31:0] fpc);
        exp_t e;
        int   maxStage;
        logic startNow;
        @(posedge clk);
        #1;
        rst          = r;
        stallreq     = req;
        timed_req    = tr;
        timed_cycles = tc;
        flush_req    = fr;
        flush_pc     = fpc;

        e.stall = 6'b0;
        e.flush = 1'b0;
        e.pc    = 32'h0;
        e.busy  = 1'b0;
        e.sc    = modelSc;
        if (r) begin
            modelTRemain = 0;
            modelHold    = 0;
            modelSc      = 32'h0;
        end else begin
            e.busy = (modelTRemain > 0) || (modelHold > 0);
            if (fr) begin
                e.flush      = 1'b1;
                e.pc         = fpc;
                modelTRemain = 0;
                modelHold    = FLUSH_HOLD;
            end else begin
                startNow = !e.busy && tr && (tc != 6'd0);
                maxStage = -1;
                for (int i = 0; i < 3; i++) begin
                    if (req[i] && reqStage(i) > maxStage) maxStage = reqStage(i);
                end
                if ((modelTRemain > 0 || startNow) && maxStage < 3) maxStage = 3;
                if (modelHold > 0 && maxStage < 0) maxStage = 0;
                if (maxStage >= 0) e.stall = 6'(((64'd1 << (maxStage + 1)) - 64'd1));
                if (modelTRemain > 0) modelTRemain--;
                else if (startNow) modelTRemain = int'(tc) - 1;
                if (modelHold > 0) modelHold--;
            end
            if (e.stall[0] && modelSc != 32'hFFFF_FFFF) modelSc = modelSc + 32'h1;
        end
        expQ.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 3'b000, 1'b0, 6'd0, 1'b0, 32'h0);
    endtask

    // Preload the stall counter after the monitor has sampled an idle cycle.
    task automatic presetCounter(input logic [31:0] val);
        @(negedge clk);
        #1;
        force dut.stall_cycles = val;
        #1;
        release dut.stall_cycles;
        modelSc = val;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("stall", {26'h0, stall}, {26'h0, e.stall});
                checkOutput("flush", {31'h0, flush}, {31'h0, e.flush});
                checkOutput("new_pc", new_pc, e.pc);
                checkOutput("busy", {31'h0, busy}, {31'h0, e.busy});
                checkOutput("stall_cycles", stall_cycles, e.sc);
            end
        end
    end

    initial begin : driver
        int wait_cycles;
        applyStimulus(1'b1, 3'b000, 1'b0, 6'd0, 1'b0, 32'h0);
        applyStimulus(1'b1, 3'b101, 1'b1, 6'd3, 1'b1, 32'h1234_5678);

        applyStimulus(1'b0, 3'b001, 1'b0, 6'd0, 1'b0, 32'h0);
        applyStimulus(1'b0, 3'b010, 1'b0, 6'd0, 1'b0, 32'h0);
        applyStimulus(1'b0, 3'b011, 1'b0, 6'd0, 1'b0, 32'h0);
        applyStimulus(1'b0, 3'b000, 1'b0, 6'd0, 1'b0, 32'h0);

        applyStimulus(1'b0, 3'b000, 1'b1, 6'd4, 1'b0, 32'h0);
        idle(5);

        applyStimulus(1'b0, 3'b000, 1'b1, 6'd4, 1'b0, 32'h0);
        applyStimulus(1'b0, 3'b000, 1'b0, 6'd0, 1'b1, 32'hBFC0_0380);
        idle(3);

        applyStimulus(1'b0, 3'b000, 1'b1, 6'd0, 1'b0, 32'h0);
        idle(1);
        applyStimulus(1'b0, 3'b000, 1'b1, 6'd1, 1'b0, 32'h0);
        idle(2);
        applyStimulus(1'b0, 3'b000, 1'b1, 6'd5, 1'b0, 32'h0);
        applyStimulus(1'b0, 3'b000, 1'b1, 6'd10, 1'b0, 32'h0);
        idle(7);

        applyStimulus(1'b0, 3'b010, 1'b1, 6'd3, 1'b1, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 3'b000, 1'b0, 6'd0, 1'b1, 32'h0000_0100);
        applyStimulus(1'b0, 3'b001, 1'b0, 6'd0, 1'b0, 32'h0);
        idle(2);

        applyStimulus(1'b0, 3'b000, 1'b1, 6'd6, 1'b0, 32'h0);
        applyStimulus(1'b1, 3'b111, 1'b0, 6'd0, 1'b0, 32'h0);
        idle(4);

        for (int n = 0; n < 300; n++) begin
            applyStimulus(($urandom_range(0, 39) == 0), 3'($urandom_range(0, 7)) & {3{$urandom_range(0, 1) == 1}},
                          ($urandom_range(0, 5) == 0), 6'($urandom_range(0, 7)),
                          ($urandom_range(0, 11) == 0), $urandom);
        end
        idle(10);

        presetCounter(32'hFFFF_FFFD);
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 3'b001, 1'b0, 6'd0, 1'b0, 32'h0);
        idle(2);

        wait_cycles = 0;
        while (expQ.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (expQ.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d entries left, required 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
